pipe_skid_reg: RTL and testbench

Parametrised successor to the plain load-enabled register. It is a ready/valid pipeline register with a one-entry skid buffer, so back-pressure on out_ready never reaches in_ready combinationally. It sustains one transfer per cycle and supports a synchronous pipeline flush. It is used between processor pipeline stages and between the cache and memory interface.

---
 rtl/pipe_skid_reg.sv | 159 +++++++++++++++
 tb/tb_pipe_skid_reg.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg
//
// Ready/valid pipeline register with a one-entry skid buffer. The main
// register drives out_data; the skid register catches the word accepted in
// the same cycle that downstream stalls. Because in_ready is decoded only from
// the registered state, back-pressure on out_ready never reaches in_ready
// combinationally. With out_ready held high the block sustains one transfer
// per cycle.
//
// A synchronous flush discards every held entry. The data registers keep
// their contents during a flush. The synchronous reset overrides flush and
// all transfers, and loads RST_VAL into both data registers.
//
// Parameters:
//   WIDTH    data width in bits
//   RST_VAL  value of both data registers after reset
//
// Ports:
//   clk        clock; all state changes on posedge
//   rst        synchronous active-high reset
//   flush      synchronous flush; discards held entries
//   in_valid   upstream data valid
//   in_ready   block can accept (decoded from registered state only)
//   in_data    upstream data
//   out_valid  out_data holds a valid entry
//   out_ready  downstream accepts
//   out_data   head entry (main register)
//   occupancy  number of held entries, 0..2
// -----------------------------------------------------------------------------
module pipe_skid_reg #(
  parameter int unsigned           WIDTH   = 32,
  parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  // EMPTY: nothing held. FULL: main valid. SKID: main and skid both valid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;

  logic in_fire;
  logic out_fire;

  // Handshakes use the decoded outputs, which depend on state only.
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // State and data registers. Reset wins over flush and every transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= RST_VAL;
      skid_q  <= RST_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Next-state and data-load logic. Data registers only change on the
  // transitions that move a word into them; everything else holds. A flush
  // empties the block without touching the data registers, so an in_fire in
  // the flush cycle is consumed and dropped, and an out_fire in the flush
  // cycle has already delivered its word downstream.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d  = in_data;
            state_d = FULL;
          end
        end

        FULL: begin
          if (in_fire && out_fire) begin
            main_d  = in_data;
            state_d = FULL;
          end else if (in_fire) begin
            // Downstream stalled this cycle: park the new word in skid.
            skid_d  = in_data;
            state_d = SKID;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end

        SKID: begin
          // in_ready is low here, so only the drain side can move.
          if (out_fire) begin
            main_d  = skid_q;
            state_d = FULL;
          end
        end

        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // Decoded outputs, functions of the registered state only.
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    occupancy = 2'd0;

    unique case (state_q)
      EMPTY: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        occupancy = 2'd0;
      end
      FULL: begin
        in_ready  = 1'b1;
        out_valid = 1'b1;
        occupancy = 2'd1;
      end
      SKID: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        occupancy = 2'd2;
      end
      default: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        occupancy = 2'd0;
      end
    endcase
  end

  assign out_data = main_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_skid_reg
//
// Directed bench for pipe_skid_reg. A table of per-cycle records gives the
// inputs for one clock edge and the outputs expected just after it. A second
// hand-written sequence streams words with single-cycle out_ready drops and
// checks ordering and occupancy against a queue model.
// -----------------------------------------------------------------------------
module tb_pipe_skid_reg;

  localparam int unsigned      WIDTH   = 32;
  localparam logic [WIDTH-1:0] RST_VAL = 32'hDEAD_BEEF;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             inValid;
  logic             inReady;
  logic [WIDTH-1:0] inData;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] outData;
  logic [1:0]       occupancy;

  int total;
  int bad;

  pipe_skid_reg #(
    .WIDTH   (WIDTH),
    .RST_VAL (RST_VAL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .in_data   (inData),
    .out_valid (outValid),
    .out_ready (outReady),
    .out_data  (outData),
    .occupancy (occupancy)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One cycle of stimulus plus the outputs expected after the edge.
  typedef struct {
    logic             rst;
    logic             flush;
    logic             inValid;
    logic [WIDTH-1:0] inData;
    logic             outReady;
    logic             expInReady;
    logic             expOutValid;
    logic [1:0]       expOcc;
    logic [WIDTH-1:0] expData;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic r, input logic f, input logic iv,
                        input logic [WIDTH-1:0] d, input logic orr,
                        input logic eIr, input logic eOv,
                        input logic [1:0] eOcc, input logic [WIDTH-1:0] eD);
    vec_t v;
    v.rst = r;  v.flush = f;  v.inValid = iv;  v.inData = d;  v.outReady = orr;
    v.expInReady = eIr;  v.expOutValid = eOv;  v.expOcc = eOcc;  v.expData = eD;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic r, input logic f, input logic iv,
                               input logic [WIDTH-1:0] d, input logic orr);
    rst      = r;
    flush    = f;
    inValid  = iv;
    inData   = d;
    outReady = orr;
  endtask

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] got,
                             input logic [WIDTH-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Build the directed table; each expected value is worked out by hand.
  task automatic buildTable();
    // Reset for two cycles.
    addVec(1, 0, 0, 32'h0, 0,   1, 0, 2'd0, RST_VAL);
    addVec(1, 0, 0, 32'h0, 0,   1, 0, 2'd0, RST_VAL);
    // Streaming 1..10 with out_ready high; occupancy stays 1.
    for (int k = 1; k <= 10; k++)
      addVec(0, 0, 1, 32'(k), 1,  1, 1, 2'd1, 32'(k));
    // Drain: main keeps its last value after going empty.
    addVec(0, 0, 0, 32'h0, 1,   1, 0, 2'd0, 32'd10);
    // Back-pressure: A accepted, B goes to skid, C refused while full.
    addVec(0, 0, 1, 32'hA0, 1,  1, 1, 2'd1, 32'hA0);
    addVec(0, 0, 1, 32'hB0, 0,  0, 1, 2'd2, 32'hA0);
    addVec(0, 0, 1, 32'hC0, 0,  0, 1, 2'd2, 32'hA0);
    addVec(0, 0, 1, 32'hC0, 1,  1, 1, 2'd1, 32'hB0);
    addVec(0, 0, 1, 32'hC0, 1,  1, 1, 2'd1, 32'hC0);
    addVec(0, 0, 0, 32'h0, 1,   1, 0, 2'd0, 32'hC0);
    // Flush from SKID with out_ready high and an offered word.
    addVec(0, 0, 1, 32'h11, 0,  1, 1, 2'd1, 32'h11);
    addVec(0, 0, 1, 32'h22, 0,  0, 1, 2'd2, 32'h11);
    addVec(0, 1, 1, 32'h33, 1,  1, 0, 2'd0, 32'h11);
    addVec(0, 0, 0, 32'h0, 1,   1, 0, 2'd0, 32'h11);
    addVec(0, 0, 1, 32'h44, 1,  1, 1, 2'd1, 32'h44);
    // Flush from FULL discards the word offered in the flush cycle.
    addVec(0, 1, 1, 32'h55, 0,  1, 0, 2'd0, 32'h44);
    // Reset and flush together while FULL with a word offered.
    addVec(0, 0, 1, 32'h66, 0,  1, 1, 2'd1, 32'h66);
    addVec(1, 1, 1, 32'h77, 0,  1, 0, 2'd0, RST_VAL);
  endtask

  // Streams 16 words with a single-cycle out_ready drop every fourth cycle
  // and checks FIFO order and occupancy against a queue of held words.
  task automatic runStreamWithDrops();
    logic [WIDTH-1:0] expQ[$];
    int sent;
    int recv;
    int cyc;
    logic inFire;
    logic outFire;
    sent = 0;
    recv = 0;
    cyc  = 0;
    while ((sent < 16 || recv < 16) && cyc < 200) begin
      applyStimulus(0, 0, (sent < 16), 32'h100 + 32'(sent), ((cyc % 4) != 2));
      @(negedge clk);
      checkOutput($sformatf("stream occ c%0d", cyc), 32'(occupancy), 32'(expQ.size()));
      inFire  = inValid & inReady;
      outFire = outValid & outReady;
      if (outFire) begin
        if (expQ.size() == 0) begin
          checkOutput($sformatf("stream spurious c%0d", cyc), outData, 32'hFFFF_FFFF);
        end else begin
          checkOutput($sformatf("stream data c%0d", cyc), outData, expQ[0]);
          void'(expQ.pop_front());
        end
        recv++;
      end
      if (inFire) begin
        expQ.push_back(inData);
        sent++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput("stream words delivered", 32'(recv), 32'd16);
    applyStimulus(0, 0, 0, 32'h0, 0);
    @(posedge clk);
    #1;
    checkOutput("stream final occ", 32'(occupancy), 32'd0);
    checkOutput("stream final out_valid", 32'(outValid), 32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    applyStimulus(1, 0, 0, 32'h0, 0);
    buildTable();

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].flush, vecs[i].inValid,
                    vecs[i].inData, vecs[i].outReady);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d in_ready", i), 32'(inReady), 32'(vecs[i].expInReady));
      checkOutput($sformatf("vec%0d out_valid", i), 32'(outValid), 32'(vecs[i].expOutValid));
      checkOutput($sformatf("vec%0d occupancy", i), 32'(occupancy), 32'(vecs[i].expOcc));
      checkOutput($sformatf("vec%0d out_data", i), outData, vecs[i].expData);
    end

    runStreamWithDrops();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
